// File: rtl/adc_snapshot_capture.sv
// Triggered snapshot capture of wide ADC words into a dual-port buffer, read back by address.
// Optional macro ADC_SNAPSHOT_FORCE_TRIGGER_EN adds a force_trigger input that triggers regardless of threshold.
module adc_snapshot_capture #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int DEPTH_LOG2     = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [16*NUMBER_OF_LINE-1:0] adc_data,
    input  logic                         adc_valid,
    input  logic                         arm,
    input  logic [2:0]                   trigger_line,
    input  logic [15:0]                  trigger_threshold,
    input  logic [DEPTH_LOG2:0]          capture_length,
`ifdef ADC_SNAPSHOT_FORCE_TRIGGER_EN
    input  logic                         force_trigger,
`endif
    output logic                         busy,
    output logic                         done,
    input  logic                         rd_en,
    input  logic [DEPTH_LOG2-1:0]        rd_addr,
    output logic [16*NUMBER_OF_LINE-1:0] rd_data,
    output logic                         rd_valid
);

    localparam int W     = 16 * NUMBER_OF_LINE;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                 state, state_next;
    logic                   rst_meta, rst_hold;
    logic [DEPTH_LOG2:0]    eff_len, len_q, wr_ptr;
    logic [2:0]             lane_q;
    logic signed [15:0]     thr_q, prev_q, cur_sample;
    logic                   seeded_q, threshold_hit, trigger;
    logic                   wr_en;
    logic [DEPTH_LOG2-1:0]  wr_addr;
    logic                   rd_zero;
    logic [W-1:0]           ram_q;
    logic [W-1:0]           mem [DEPTH];

    // Reset asserts immediately but is released through two flops, so the
    // logic stays frozen for two edges after deassertion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_meta <= 1'b1;
            rst_hold <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_hold <= rst_meta;
        end
    end

    always_comb begin
        eff_len = capture_length;
        if (capture_length == '0 || capture_length > FULL_LEN)
            eff_len = FULL_LEN;
    end

    always_comb begin
        cur_sample = '0;
        for (int k = 0; k < NUMBER_OF_LINE; k++)
            if (lane_q == 3'(k))
                cur_sample = adc_data[16*k +: 16];
    end

    assign threshold_hit = seeded_q && (prev_q < thr_q) && (cur_sample >= thr_q);
`ifdef ADC_SNAPSHOT_FORCE_TRIGGER_EN
    assign trigger = adc_valid && (threshold_hit || force_trigger);
`else
    assign trigger = adc_valid && threshold_hit;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (!rst_hold)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr[DEPTH_LOG2-1:0];
        case (state)
            IDLE, DONE: begin
                if (arm)
                    state_next = ARMED;
            end
            ARMED: begin
                if (trigger) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    state_next = (len_q == 1) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == len_q - 1'b1)
                        state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ARMED) || (state == CAPTURE);
    assign done = (state == DONE);

    // Capture bookkeeping and read-side qualifiers; a read issued while busy
    // is flagged so its returned word is blanked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            prev_q   <= '0;
            seeded_q <= 1'b0;
            lane_q   <= '0;
            thr_q    <= '0;
            len_q    <= '0;
            rd_valid <= 1'b0;
            rd_zero  <= 1'b0;
        end else if (!rst_hold) begin
            rd_valid <= rd_en;
            rd_zero  <= busy;
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        lane_q   <= trigger_line;
                        thr_q    <= trigger_threshold;
                        len_q    <= eff_len;
                        seeded_q <= 1'b0;
                        wr_ptr   <= '0;
                    end
                end
                ARMED: begin
                    if (adc_valid) begin
                        prev_q   <= cur_sample;
                        seeded_q <= 1'b1;
                        if (trigger)
                            wr_ptr <= 1;
                    end
                end
                CAPTURE: begin
                    if (adc_valid)
                        wr_ptr <= wr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= adc_data;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

    assign rd_data = (rd_valid && !rd_zero) ? ram_q : '0;

endmodule

// File: tb/tb_adc_snapshot_capture.sv
// Directed self-checking bench for adc_snapshot_capture (default parameters).
// Covers force_trigger only when ADC_SNAPSHOT_FORCE_TRIGGER_EN is defined.
module tb_adc_snapshot_capture;

    localparam int N = 8;
    localparam int D = 10;
    localparam int W = 16 * N;

    logic           clock;
    logic           reset;
    logic [W-1:0]   adc_data;
    logic           adc_valid;
    logic           arm;
    logic [2:0]     trigger_line;
    logic [15:0]    trigger_threshold;
    logic [D:0]     capture_length;
`ifdef ADC_SNAPSHOT_FORCE_TRIGGER_EN
    logic           force_trigger;
`endif
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [D-1:0]   rd_addr;
    logic [W-1:0]   rd_data;
    logic           rd_valid;

    int tests    = 0;
    int failures = 0;

    adc_snapshot_capture #(.NUMBER_OF_LINE(N), .DEPTH_LOG2(D)) dut (
        .clock(clock),
        .reset(reset),
        .adc_data(adc_data),
        .adc_valid(adc_valid),
        .arm(arm),
        .trigger_line(trigger_line),
        .trigger_threshold(trigger_threshold),
        .capture_length(capture_length),
`ifdef ADC_SNAPSHOT_FORCE_TRIGGER_EN
        .force_trigger(force_trigger),
`endif
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] word_all(input int v);
        logic [W-1:0] w;
        for (int k = 0; k < N; k++)
            w[16*k +: 16] = 16'(v);
        return w;
    endfunction

    // Lane 2 carries v exactly; the other lanes are offset so they are distinguishable.
    function automatic logic [W-1:0] ramp_word(input int v);
        logic [W-1:0] w;
        for (int k = 0; k < N; k++)
            w[16*k +: 16] = 16'(v + (k - 2) * 1000);
        return w;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] data, input logic valid);
        adc_data  = data;
        adc_valid = valid;
        tick;
        adc_valid = 1'b0;
    endtask

    task automatic armCapture(input int line, input int thr, input int len);
        trigger_line      = 3'(line);
        trigger_threshold = 16'(thr);
        capture_length    = (D+1)'(len);
        arm = 1'b1;
        tick;
        arm = 1'b0;
    endtask

    task automatic readWord(input int addr, output logic [W-1:0] data, output logic valid);
        adc_valid = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = D'(addr);
        tick;
        rd_en = 1'b0;
        data  = rd_data;
        valid = rd_valid;
    endtask

    initial begin
        logic [W-1:0] d;
        logic         vld;
        int           done_at;
        logic         busy_at_trig;

        reset = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0;
        trigger_line = '0; trigger_threshold = '0; capture_length = '0;
        rd_en = 1'b0; rd_addr = '0;
`ifdef ADC_SNAPSHOT_FORCE_TRIGGER_EN
        force_trigger = 1'b0;
`endif
        repeat (3) tick;
        checkOutput("reset_busy", W'(busy), W'(0));
        checkOutput("reset_done", W'(done), W'(0));
        checkOutput("reset_rd_valid", W'(rd_valid), W'(0));
        checkOutput("reset_rd_data", rd_data, '0);
        reset = 1'b0;
        repeat (3) tick;

        // Lane 2 ramp, threshold 0, length 16
        armCapture(2, 0, 16);
        checkOutput("ramp_armed_busy", W'(busy), W'(1));
        done_at = -1000;
        busy_at_trig = 1'b0;
        for (int v = -100; v <= 100; v++) begin
            applyStimulus(ramp_word(v), 1'b1);
            if (v == 0) busy_at_trig = busy;
            if (done && done_at == -1000) done_at = v;
        end
        checkOutput("ramp_busy_after_trig", W'(busy_at_trig), W'(1));
        checkOutput("ramp_done_at", W'(done_at), W'(15));
        for (int i = 0; i < 16; i++) begin
            readWord(i, d, vld);
            checkOutput("ramp_rd_valid", W'(vld), W'(1));
            checkOutput("ramp_lane2", W'(d[47:32]), W'(i));
        end
        readWord(5, d, vld);
        checkOutput("ramp_word5", d, ramp_word(5));
        tick;
        checkOutput("rd_valid_single", W'(rd_valid), W'(0));

        // Gappy valid, length 4
        armCapture(0, 10, 4);
        applyStimulus(word_all(0), 1'b1);
        applyStimulus(word_all(20), 1'b1);
        applyStimulus(word_all(21), 1'b1);
        applyStimulus(word_all(999), 1'b0);
        applyStimulus(word_all(22), 1'b1);
        applyStimulus(word_all(999), 1'b0);
        checkOutput("gap_not_done", W'(done), W'(0));
        applyStimulus(word_all(23), 1'b1);
        checkOutput("gap_done", W'(done), W'(1));
        for (int i = 0; i < 4; i++) begin
            readWord(i, d, vld);
            checkOutput("gap_word", d, word_all(20 + i));
        end

        // Length 0 and 2000 both saturate to 1024
        for (int pass = 0; pass < 2; pass++) begin
            int base = (pass == 0) ? 100 : 2000;
            armCapture(0, 10, (pass == 0) ? 0 : 2000);
            applyStimulus(word_all(0), 1'b1);
            done_at = -1;
            for (int i = 0; i < 1100; i++) begin
                applyStimulus(word_all(base + i), 1'b1);
                if (done) begin
                    done_at = i;
                    break;
                end
            end
            checkOutput("sat_done_at", W'(done_at), W'(1023));
            readWord(0, d, vld);
            checkOutput("sat_addr0", W'(d[15:0]), W'(base));
            readWord(1023, d, vld);
            checkOutput("sat_addr1023", W'(d[15:0]), W'(base + 1023));
        end

        // Length 1 goes straight to DONE
        armCapture(0, 10, 1);
        applyStimulus(word_all(0), 1'b1);
        applyStimulus(word_all(55), 1'b1);
        checkOutput("len1_done", W'(done), W'(1));
        checkOutput("len1_busy", W'(busy), W'(0));
        readWord(0, d, vld);
        checkOutput("len1_addr0", W'(d[15:0]), W'(55));

        // First sample above threshold only seeds
        armCapture(0, 0, 16);
        repeat (20) applyStimulus(word_all(500), 1'b1);
        checkOutput("seed_busy", W'(busy), W'(1));
        checkOutput("seed_done", W'(done), W'(0));
        readWord(0, d, vld);
        checkOutput("armed_rd_valid", W'(vld), W'(1));
        checkOutput("armed_rd_zero", d, '0);

        // Re-arm while ARMED must be ignored (would raise threshold to 1000, length 1)
        armCapture(0, 1000, 1);
        applyStimulus(word_all(-5), 1'b1);
        applyStimulus(word_all(5), 1'b1);
        checkOutput("rearm_ignored_busy", W'(busy), W'(1));
        checkOutput("rearm_ignored_done", W'(done), W'(0));
        readWord(0, d, vld);
        checkOutput("capture_rd_valid", W'(vld), W'(1));
        checkOutput("capture_rd_zero", d, '0);

        // Reset asynchronously at capture word 7
        for (int i = 6; i < 12; i++) applyStimulus(word_all(i), 1'b1);
        adc_data  = word_all(12);
        adc_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_busy", W'(busy), W'(0));
        checkOutput("async_done", W'(done), W'(0));
        checkOutput("async_rd_valid", W'(rd_valid), W'(0));
        adc_valid = 1'b0;
        repeat (2) tick;
        reset = 1'b0;
        armCapture(0, 0, 2);
        checkOutput("release_hold", W'(busy), W'(0));
        repeat (3) tick;
        armCapture(0, 0, 2);
        checkOutput("rearm_busy", W'(busy), W'(1));
        applyStimulus(word_all(-1), 1'b1);
        applyStimulus(word_all(77), 1'b1);
        applyStimulus(word_all(78), 1'b1);
        checkOutput("recap_done", W'(done), W'(1));
        readWord(0, d, vld);
        checkOutput("recap_addr0", d, word_all(77));
        readWord(1, d, vld);
        checkOutput("recap_addr1", d, word_all(78));

`ifdef ADC_SNAPSHOT_FORCE_TRIGGER_EN
        armCapture(0, 1000, 4);
        applyStimulus(word_all(0), 1'b1);
        force_trigger = 1'b1;
        applyStimulus(word_all(16'h1234), 1'b1);
        force_trigger = 1'b0;
        checkOutput("force_busy", W'(busy), W'(1));
        readWord(0, d, vld);
        checkOutput("force_capture_rd_valid", W'(vld), W'(1));
        checkOutput("force_capture_rd_zero", d, '0);
        for (int i = 1; i < 4; i++) applyStimulus(word_all(i), 1'b1);
        checkOutput("force_done", W'(done), W'(1));
        readWord(0, d, vld);
        checkOutput("force_addr0", W'(d[15:0]), W'(16'h1234));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/adc_snapshot_capture.md
ADC_SNAPSHOT_CAPTURE -- requirements
Module: adc_snapshot_capture

Interface
REQ-001 SHALL have parameter NUMBER_OF_LINE, default 8, meaning 16-bit samples per clock word.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of buffer depth in words.
REQ-003 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port adc_data  in  16*NUMBER_OF_LINE  registered ADC word from the tile monitor stage, lane k at bits [16k+15:16k].
REQ-006 SHALL have port adc_valid  in  1  adc_data qualifier.
REQ-007 SHALL have port arm  in  1  single-cycle request to start a capture.
REQ-008 SHALL have port trigger_line  in  3  lane compared against the threshold.
REQ-009 SHALL have port trigger_threshold  in  16  signed two's-complement threshold.
REQ-010 SHALL have port capture_length  in  DEPTH_LOG2+1  words to store.
REQ-011 SHALL have port busy  out  1  high in ARMED or CAPTURE.
REQ-012 SHALL have port done  out  1  high in DONE.
REQ-013 SHALL have port rd_en  in  1  read strobe.
REQ-014 SHALL have port rd_addr  in  DEPTH_LOG2  read word address.
REQ-015 SHALL have port rd_data  out  16*NUMBER_OF_LINE  read word.
REQ-016 SHALL have port rd_valid  out  1  rd_data qualifier.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-018 IDLE or DONE + arm=1 SHALL go to ARMED next cycle, latching trigger_line, trigger_threshold and effective length L.
REQ-019 L SHALL be capture_length, with 0 or any value above 2^DEPTH_LOG2 mapped to 2^DEPTH_LOG2.
REQ-020 arm SHALL be ignored in ARMED and CAPTURE.
REQ-021 Trigger SHALL be a rising crossing: two consecutive valid samples on the latched lane with previous < threshold and current >= threshold, signed compare.
REQ-022 The first valid sample after entering ARMED SHALL only seed the previous-sample register and SHALL NOT trigger.
REQ-023 On trigger, the triggering word SHALL be written to address 0 and the state SHALL become CAPTURE, or DONE directly if L=1.
REQ-024 In CAPTURE each adc_valid word SHALL be written to the next address; cycles with adc_valid=0 SHALL write nothing.
REQ-025 After word L-1 is written the state SHALL become DONE the next cycle; no write SHALL ever exceed address L-1.
REQ-026 rd_data SHALL equal the word at rd_addr one cycle after rd_en, with rd_valid high for exactly that cycle.
REQ-027 A read in IDLE or DONE SHALL return stored data; a read in ARMED or CAPTURE SHALL return all zeros with rd_valid still asserted.
REQ-028 Addresses >= L SHALL return the buffer content unchanged (stale or undefined).
REQ-029 Buffer storage SHALL be inferable as simple dual-port block RAM.

Reset
REQ-030 Reset SHALL force state IDLE, busy=0, done=0, rd_valid=0, rd_data=0, write pointer 0, previous-sample register 0.
REQ-031 Reset SHALL take effect immediately and asynchronously, including mid-capture; buffer contents need not be cleared.
REQ-032 Release SHALL be synchronised internally so the first state change occurs no earlier than the second clock edge after deassertion.

Configuration
REQ-033 With macro ADC_SNAPSHOT_FORCE_TRIGGER_EN defined, the block SHALL have an extra input force_trigger (1 bit) that, when asserted in ARMED with adc_valid=1, acts as a trigger on that word regardless of the threshold.
REQ-034 Without ADC_SNAPSHOT_FORCE_TRIGGER_EN, port force_trigger SHALL NOT exist and only the threshold trigger SHALL apply.

Verification
REQ-035 Lane 2 ramp -100 to +100 step 1, threshold 0, length 16, arm -> capture starts at the word where lane2=0, done after 16 valid words, rd addr 0..15 returns lane2 0..15.
REQ-036 adc_valid toggling 1/0 during capture, length 4 -> exactly 4 words stored, no gaps, done 1 cycle after the 4th valid word.
REQ-037 capture_length=0 -> 1024 words captured (DEPTH_LOG2=10); capture_length=2000 -> also 1024.
REQ-038 First ARMED sample=+500 on lane 0, threshold 0, all later samples +500 -> no trigger, busy stays 1.
REQ-039 Reset asserted at capture word 7 -> busy=0 and done=0 the same cycle; a later arm recaptures from address 0.
REQ-040 With ADC_SNAPSHOT_FORCE_TRIGGER_EN, force_trigger in ARMED at a word of value 0x1234 -> address 0 holds 0x1234; a read during CAPTURE returns 0 with rd_valid=1.
